// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: on a $4014 write it halts the CPU and copies one 256-byte
// CPU page into PPU OAMDATA, one read/write cycle pair per byte.
module oam_dma #(
    parameter logic [2:0] OAMDATA_ADDR = 3'd4,
    parameter bit         ALIGN_EN     = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        REG_WR,
    input  logic [7:0]  REG_DATA,
    output logic        CPU_RDY,
    output logic        DMA_ACTIVE,
    output logic [15:0] BUS_ADDR,
    output logic        BUS_RD,
    input  logic [7:0]  BUS_DATA_IN,
    output logic [2:0]  PPU_CPU_ADDR,
    output logic [7:0]  PPU_CPU_DATA,
    output logic        PPU_CPU_wren,
    output logic [2:0]  DBG_STATE
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       parity_q;

    // State register: everything clears asynchronously, so a mid-transfer reset
    // drops the bus immediately and nothing is replayed.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            parity_q <= ~parity_q;
        end
    end

    // Handshake: REG_WR is a one-cycle strobe accepted only in IDLE (strobes in
    // any other state are dropped); CPU_RDY=0 means the DMA owns the CPU bus.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (REG_WR) begin
                    page_d  = REG_DATA;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            HALT: begin
                // Reads must land on parity-0 cycles; burn one cycle if READ would be odd.
                if (ALIGN_EN && !parity_q) state_d = ALIGN;
                else                       state_d = READ;
            end
            ALIGN: state_d = READ;
            READ: begin
                data_d  = BUS_DATA_IN;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d   = idx_q + 8'h01;
                state_d = (idx_q == 8'hFF) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        CPU_RDY      = 1'b1;
        DMA_ACTIVE   = 1'b0;
        BUS_RD       = 1'b0;
        PPU_CPU_wren = 1'b0;
        PPU_CPU_ADDR = 3'd0;
        case (state_q)
            IDLE: begin
                CPU_RDY    = 1'b1;
                DMA_ACTIVE = 1'b0;
            end
            HALT, ALIGN: begin
                CPU_RDY    = 1'b0;
                DMA_ACTIVE = 1'b1;
            end
            READ: begin
                CPU_RDY    = 1'b0;
                DMA_ACTIVE = 1'b1;
                BUS_RD     = 1'b1;
            end
            WRITE: begin
                CPU_RDY      = 1'b0;
                DMA_ACTIVE   = 1'b1;
                PPU_CPU_wren = 1'b1;
                PPU_CPU_ADDR = OAMDATA_ADDR;
            end
            default: begin
                CPU_RDY    = 1'b1;
                DMA_ACTIVE = 1'b0;
            end
        endcase
    end

    assign BUS_ADDR     = {page_q, idx_q};
    assign PPU_CPU_DATA = data_q;
    assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: random page memory, cycle-level monitor and a transfer-level
// reference model (expected address list, data bytes, halt length, read parity).
module tb_oam_dma;
    logic        CLK = 1'b0;
    logic        RESET_n;
    logic        REG_WR;
    logic [7:0]  REG_DATA;
    logic        CPU_RDY;
    logic        DMA_ACTIVE;
    logic [15:0] BUS_ADDR;
    logic        BUS_RD;
    logic [7:0]  BUS_DATA_IN;
    logic [2:0]  PPU_CPU_ADDR;
    logic [7:0]  PPU_CPU_DATA;
    logic        PPU_CPU_wren;
    logic [2:0]  DBG_STATE;

    logic [7:0]  mem [0:65535];
    int          n_cyc;
    int          checks = 0;
    int          fails = 0;

    oam_dma dut (
        .CLK          (CLK),
        .RESET_n      (RESET_n),
        .REG_WR       (REG_WR),
        .REG_DATA     (REG_DATA),
        .CPU_RDY      (CPU_RDY),
        .DMA_ACTIVE   (DMA_ACTIVE),
        .BUS_ADDR     (BUS_ADDR),
        .BUS_RD       (BUS_RD),
        .BUS_DATA_IN  (BUS_DATA_IN),
        .PPU_CPU_ADDR (PPU_CPU_ADDR),
        .PPU_CPU_DATA (PPU_CPU_DATA),
        .PPU_CPU_wren (PPU_CPU_wren),
        .DBG_STATE    (DBG_STATE)
    );

    always #5 CLK = ~CLK;

    always_comb BUS_DATA_IN = mem[BUS_ADDR];

    // Cycle number since reset release; its LSB is the expected parity of that cycle.
    always @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) n_cyc <= 0;
        else          n_cyc <= n_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_rdy"}, CPU_RDY, 1);
        check({tag, "_active"}, DMA_ACTIVE, 0);
        check({tag, "_bus_rd"}, BUS_RD, 0);
        check({tag, "_wren"}, PPU_CPU_wren, 0);
        check({tag, "_bus_addr"}, BUS_ADDR, 16'h0000);
        check({tag, "_ppu_addr"}, PPU_CPU_ADDR, 3'd0);
        check({tag, "_ppu_data"}, PPU_CPU_DATA, 8'h00);
    endtask

    // Move to a negedge whose following cycle (the HALT cycle) has parity hp.
    task automatic align_halt(input int hp);
        @(negedge CLK);
        if (((n_cyc + 1) % 2) != hp) @(negedge CLK);
    endtask

    // Strobe $4014 with page, monitor the whole halt, then compare with the model.
    task automatic run_dma(input string tag, input logic [7:0] page, input int pre_wait,
                           input int inject_rd, input bit inject_final, input int reset_rd);
        logic [15:0] rd_q[$];
        logic [7:0]  wd_q[$];
        logic [15:0] a;
        int strobe_cyc, halt_par, halt_len, first_rd, t;
        int par_bad, both_bad, act_bad, addr_bad, rd_err, wd_err;
        bit did_reset;
        par_bad = 0; both_bad = 0; act_bad = 0; addr_bad = 0; rd_err = 0; wd_err = 0;
        halt_len = 0; first_rd = -1; t = 0; did_reset = 0;

        repeat (pre_wait) @(negedge CLK);
        strobe_cyc = n_cyc;
        halt_par   = (strobe_cyc + 1) % 2;
        REG_WR     = 1'b1;
        REG_DATA   = page;
        @(negedge CLK);
        REG_WR   = 1'b0;
        REG_DATA = 8'($urandom);
        check({tag, "_halt_next_cycle"}, CPU_RDY, 0);

        while (CPU_RDY == 1'b0 && t < 600) begin
            REG_WR = 1'b0;
            halt_len++;
            if (DMA_ACTIVE !== 1'b1) act_bad++;
            if (BUS_RD && PPU_CPU_wren) both_bad++;
            if (BUS_RD) begin
                if (first_rd < 0) first_rd = n_cyc;
                if ((n_cyc % 2) != 0) par_bad++;
                rd_q.push_back(BUS_ADDR);
                if (reset_rd == rd_q.size() - 1) begin
                    RESET_n = 1'b0;
                    #1;
                    check_reset_outputs({tag, "_async_rst"});
                    did_reset = 1;
                    break;
                end
                if (inject_rd == rd_q.size() - 1) begin
                    REG_WR   = 1'b1;
                    REG_DATA = 8'h05;
                end
            end
            if (PPU_CPU_wren) begin
                wd_q.push_back(PPU_CPU_DATA);
                if (PPU_CPU_ADDR !== 3'd4) addr_bad++;
                if (inject_final && wd_q.size() == 256) begin
                    REG_WR   = 1'b1;
                    REG_DATA = 8'h77;
                end
            end
            @(negedge CLK);
            t++;
        end
        REG_WR = 1'b0;

        for (int i = 0; i < wd_q.size(); i++) begin
            a = {page, 8'(i)};
            if (wd_q[i] !== mem[a]) wd_err++;
        end
        for (int i = 0; i < rd_q.size(); i++) begin
            a = {page, 8'(i)};
            if (rd_q[i] !== a) rd_err++;
        end
        check({tag, "_wr_data_errs"}, wd_err, 0);
        check({tag, "_rd_addr_errs"}, rd_err, 0);

        if (did_reset) begin
            repeat (2) @(negedge CLK);
            check_reset_outputs({tag, "_rst_held"});
            RESET_n = 1'b1;
            check({tag, "_wren_before_rst"}, wd_q.size(), 64);
        end else begin
            check({tag, "_done_in_budget"}, CPU_RDY, 1);
            check({tag, "_active_low"}, DMA_ACTIVE, 0);
            check({tag, "_idle_no_rd"}, BUS_RD, 0);
            check({tag, "_idle_no_wren"}, PPU_CPU_wren, 0);
            check({tag, "_halt_len"}, halt_len, (halt_par == 1) ? 513 : 514);
            check({tag, "_first_rd_delay"}, first_rd - strobe_cyc, (halt_par == 1) ? 2 : 3);
            check({tag, "_rd_count"}, rd_q.size(), 256);
            check({tag, "_wr_count"}, wd_q.size(), 256);
            check({tag, "_rd_parity_errs"}, par_bad, 0);
            check({tag, "_rd_wren_overlap"}, both_bad, 0);
            check({tag, "_active_vs_rdy"}, act_bad, 0);
            check({tag, "_wr_reg_errs"}, addr_bad, 0);
            if (inject_final) begin
                @(negedge CLK);
                check({tag, "_final_strobe_ignored"}, CPU_RDY, 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        REG_WR   = 1'b0;
        REG_DATA = 8'h00;
        RESET_n  = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset_held");
        RESET_n = 1'b1;

        align_halt(1);
        run_dma("t1_par1", 8'h02, 0, -1, 0, -1);
        align_halt(0);
        run_dma("t2_par0", 8'h02, 0, -1, 0, -1);
        run_dma("t3_pageff", 8'hFF, $urandom_range(1, 3), -1, 0, -1);
        run_dma("t4_ignore", 8'h03, $urandom_range(1, 3), 8'h10, 0, -1);
        run_dma("t5_reset", 8'h11, $urandom_range(1, 3), -1, 0, 8'h40);
        run_dma("t5_after", 8'($urandom), $urandom_range(1, 3), -1, 0, -1);
        run_dma("t6_first", 8'h21, 1, -1, 0, -1);
        run_dma("t6_back2back", 8'h22, 0, -1, 0, -1);
        run_dma("final_wr_strobe", 8'h40, 2, -1, 1, -1);
        for (int k = 0; k < 3; k++)
            run_dma("rand", 8'($urandom), $urandom_range(0, 4), -1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
